// File: rtl/mtimer_bank.sv
// Machine-timer bank: 64-bit mtime, NUM_CMP mtimecmp comparators, tick
// prescaler, enable and a race-free mtimeh snapshot on the core data port.
// Ports: clk, rst (async active-low); req_i/we_i/addr_i/wdata_i bus request;
//   hit_o/err_o/rdata_o combinational response; irq_o per comparator;
//   mtime_o current counter value.
module mtimer_bank #(
    parameter int          NUM_CMP    = 1,
    parameter int          PRESCALE_W = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               hit_o,
    output logic               err_o,
    output logic [31:0]        rdata_o,
    output logic [NUM_CMP-1:0] irq_o,
    output logic [63:0]        mtime_o
);

    localparam logic [31:0] WIN = 32'(16 + 8 * NUM_CMP);

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q [NUM_CMP];
    logic [63:0]           cmp_d [NUM_CMP];
    logic                  en_q, en_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [31:0]           snap_q, snap_d;
    logic [NUM_CMP-1:0]    irq_q, irq_d;

    logic [31:0] off;
    logic [4:0]  widx;
    logic        acc_ok, wr, rd, tick;
    logic [31:0] ctrl_rd;

    // Unsigned wrap makes addresses below BASE_ADDR fall outside too.
    assign off    = addr_i - BASE_ADDR;
    assign hit_o  = (off < WIN);
    assign widx   = off[6:2];
    assign err_o  = req_i & hit_o & (addr_i[1:0] != 2'b00);
    assign acc_ok = req_i & hit_o & (addr_i[1:0] == 2'b00);
    assign wr     = acc_ok & we_i;
    assign rd     = acc_ok & ~we_i;
    assign tick   = en_q & (cnt_q == presc_q);

    assign irq_o   = irq_q;
    assign mtime_o = mtime_q;

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[0] = en_q;
        ctrl_rd[8 +: PRESCALE_W] = presc_q;
    end

    always_comb begin
        rdata_o = '0;
        if (hit_o) begin
            case (widx)
                5'd0: rdata_o = mtime_q[31:0];
                5'd1: rdata_o = mtime_q[63:32];
                5'd2: rdata_o = ctrl_rd;
                5'd3: rdata_o = snap_q;
                default: begin
                    for (int i = 0; i < NUM_CMP; i++) begin
                        if (widx == 5'(4 + 2 * i)) rdata_o = cmp_q[i][31:0];
                        if (widx == 5'(5 + 2 * i)) rdata_o = cmp_q[i][63:32];
                    end
                end
            endcase
        end
    end

    always_comb begin
        en_d    = en_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        mtime_d = mtime_q;
        snap_d  = snap_q;
        for (int i = 0; i < NUM_CMP; i++) cmp_d[i] = cmp_q[i];

        if (tick)      cnt_d = '0;
        else if (en_q) cnt_d = cnt_q + PRESCALE_W'(1);

        if (wr && widx == 5'd2) begin
            en_d    = wdata_i[0];
            presc_d = wdata_i[8 +: PRESCALE_W];
            cnt_d   = '0;
        end

        // Half writes override the tick; a tick in that edge is dropped.
        // en_d gates the tick so a CTRL write clearing EN blocks it.
        if (wr && widx == 5'd0)      mtime_d[31:0]  = wdata_i;
        else if (wr && widx == 5'd1) mtime_d[63:32] = wdata_i;
        else if (tick && en_d)       mtime_d = mtime_q + 64'd1;

        if (rd && widx == 5'd0) snap_d = mtime_q[63:32];

        for (int i = 0; i < NUM_CMP; i++) begin
            if (wr && widx == 5'(4 + 2 * i)) cmp_d[i][31:0]  = wdata_i;
            if (wr && widx == 5'(5 + 2 * i)) cmp_d[i][63:32] = wdata_i;
        end

        for (int i = 0; i < NUM_CMP; i++)
            irq_d[i] = en_d & (mtime_d >= cmp_d[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q <= '0;
            en_q    <= 1'b1;
            presc_q <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            irq_q   <= '0;
            for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
        end else begin
            mtime_q <= mtime_d;
            en_q    <= en_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= cmp_d[i];
        end
    end

endmodule

// File: tb/tb_mtimer_bank.sv
// Directed bench for mtimer_bank: counting, prescaler, wrap, snapshot,
// comparator irq, write/tick priority, misaligned access and async reset.
module tb_mtimer_bank;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        hit, err;
    logic [31:0] rdata;
    logic [0:0]  irq;
    logic [63:0] mtime;
    logic        hit4, err4;
    logic [31:0] rdata4;
    logic [3:0]  irq4;
    logic [63:0] mtime4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mtimer_bank #(.NUM_CMP(1), .PRESCALE_W(8), .BASE_ADDR(BASE)) u1 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .hit_o(hit), .err_o(err), .rdata_o(rdata),
        .irq_o(irq), .mtime_o(mtime)
    );

    mtimer_bank #(.NUM_CMP(4), .PRESCALE_W(8), .BASE_ADDR(BASE)) u4 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .hit_o(hit4), .err_o(err4), .rdata_o(rdata4),
        .irq_o(irq4), .mtime_o(mtime4)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = BASE + off; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = BASE + off;
        #1 d = rdata;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (mtime !== 64'd0) begin
            n_bad++; $display("FAIL rst_mtime got %h want 0", mtime);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL rst_irq got %b want 0", irq);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(10);
        n_cmp++;
        if (mtime !== 64'd10) begin
            n_bad++; $display("FAIL count10 got %0d want 10", mtime);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL count10_irq got %b want 0", irq);
        end
        req = 1'b1; we = 1'b0; addr = BASE + 32'h8;
        #1;
        n_cmp++;
        if (rdata !== 32'h1) begin
            n_bad++; $display("FAIL ctrl_rst got %h want 1", rdata);
        end
        req = 1'b0;
    endtask

    task automatic test_prescaler;
        logic [31:0] d;
        bus_write(32'h8, 32'h0000_0300);
        n_cmp++;
        if (mtime !== 64'd10) begin
            n_bad++; $display("FAIL en0_block got %0d want 10", mtime);
        end
        bus_write(32'h8, 32'h0000_0301);
        idle(3);
        n_cmp++;
        if (mtime !== 64'd10) begin
            n_bad++; $display("FAIL presc_3clk got %0d want 10", mtime);
        end
        idle(1);
        n_cmp++;
        if (mtime !== 64'd11) begin
            n_bad++; $display("FAIL presc_4clk got %0d want 11", mtime);
        end
        idle(8);
        n_cmp++;
        if (mtime !== 64'd13) begin
            n_bad++; $display("FAIL presc_12clk got %0d want 13", mtime);
        end
        bus_read(32'h8, d);
        n_cmp++;
        if (d !== 32'h0000_0301) begin
            n_bad++; $display("FAIL ctrl_rb got %h want 301", d);
        end
    endtask

    task automatic test_wrap_snap;
        logic [31:0] d;
        bus_write(32'h8, 32'h0000_0001);
        bus_write(32'h0, 32'hFFFF_FFFF);
        bus_write(32'h4, 32'h0);
        n_cmp++;
        if (mtime !== 64'h0000_0000_FFFF_FFFF) begin
            n_bad++; $display("FAIL wr_no_tick got %h want ffffffff", mtime);
        end
        idle(1);
        n_cmp++;
        if (mtime !== 64'h1_0000_0000) begin
            n_bad++; $display("FAIL carry got %h want 100000000", mtime);
        end
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL rd_lo got %h want 0", d);
        end
        bus_read(32'hC, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++; $display("FAIL snap got %h want 1", d);
        end
        bus_write(32'h0, 32'hFFFF_FFFF);
        bus_write(32'h4, 32'hFFFF_FFFF);
        n_cmp++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++; $display("FAIL all1 got %h want all ones", mtime);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL irq_eq got %b want 1", irq);
        end
        idle(1);
        n_cmp++;
        if (mtime !== 64'd0) begin
            n_bad++; $display("FAIL wrap64 got %h want 0", mtime);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL irq_wrap got %b want 0", irq);
        end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        bus_write(32'h10, 32'd20);
        bus_write(32'h14, 32'd0);
        bus_write(32'h0, 32'd0);
        idle(19);
        n_cmp++;
        if (mtime !== 64'd19 || irq !== 1'b0) begin
            n_bad++; $display("FAIL irq_19 got %0d/%b want 19/0", mtime, irq);
        end
        idle(1);
        n_cmp++;
        if (mtime !== 64'd20 || irq !== 1'b1) begin
            n_bad++; $display("FAIL irq_20 got %0d/%b want 20/1", mtime, irq);
        end
        idle(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL irq_level got %b want 1", irq);
        end
        bus_write(32'h14, 32'd1);
        n_cmp++;
        if (mtime !== 64'd22 || irq !== 1'b0) begin
            n_bad++; $display("FAIL irq_clr got %0d/%b want 22/0", mtime, irq);
        end
        bus_read(32'h14, d);
        n_cmp++;
        if (d !== 32'd1) begin
            n_bad++; $display("FAIL cmp_hi got %h want 1", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        bus_write(32'h0, 32'h1234_5678);
        n_cmp++;
        if (mtime !== 64'h1234_5678) begin
            n_bad++; $display("FAIL wr_tick got %h want 12345678", mtime);
        end
        req = 1'b1; we = 1'b0; addr = BASE + 32'h2;
        #1;
        n_cmp++;
        if (err !== 1'b1 || hit !== 1'b1) begin
            n_bad++; $display("FAIL err_ld got %b/%b want 1/1", err, hit);
        end
        @(negedge clk);
        req = 1'b0;
        bus_read(32'hC, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++; $display("FAIL snap_keep got %h want 1", d);
        end
        bus_write(32'h1, 32'h0);
        bus_write(32'h9, 32'h0);
        n_cmp++;
        if (mtime !== 64'h1234_567C) begin
            n_bad++; $display("FAIL err_st got %h want 1234567c", mtime);
        end
    endtask

    task automatic test_window;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = BASE + 32'h14;
        #1;
        n_cmp++;
        if (hit !== 1'b1) begin
            n_bad++; $display("FAIL hit_14 got %b want 1", hit);
        end
        addr = BASE + 32'h18;
        #1;
        n_cmp++;
        if (hit !== 1'b0 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL miss_18 got %b/%h want 0/0", hit, rdata);
        end
        @(negedge clk);
        addr = BASE + 32'h2C;
        #1;
        n_cmp++;
        if (hit4 !== 1'b1 || hit !== 1'b0) begin
            n_bad++; $display("FAIL hit_2c got %b/%b want 1/0", hit4, hit);
        end
        addr = BASE + 32'h30;
        #1;
        n_cmp++;
        if (hit4 !== 1'b0) begin
            n_bad++; $display("FAIL miss_30 got %b want 0", hit4);
        end
        @(negedge clk);
        addr = BASE - 32'h4;
        #1;
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++; $display("FAIL miss_below got %b want 0", hit);
        end
        req = 1'b0;
    endtask

    task automatic test_async_reset;
        bus_write(32'h0, 32'd55);
        bus_write(32'h10, 32'd50);
        bus_write(32'h14, 32'd0);
        n_cmp++;
        if (mtime !== 64'd57 || irq !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst got %0d/%b want 57/1", mtime, irq);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (mtime !== 64'd0 || irq !== 1'b0) begin
            n_bad++; $display("FAIL async_rst got %0d/%b want 0/0", mtime, irq);
        end
        req = 1'b1; we = 1'b0; addr = BASE + 32'h10;
        #1;
        n_cmp++;
        if (rdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL rst_cmp got %h want ffffffff", rdata);
        end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        n_cmp++;
        if (mtime !== 64'd3) begin
            n_bad++; $display("FAIL post_rst got %0d want 3", mtime);
        end
    endtask

    initial begin
        test_reset;
        test_prescaler;
        test_wrap_snap;
        test_irq;
        test_back_to_back;
        test_window;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
